// File: rtl/prbs_checker.sv
// PRBS receive checker: self-synchronises a local LFSR to the incoming stream, declares lock,
// counts bit errors and detects loss of lock. Define PRBS_CHECKER_AUTORELOCK_EN for auto-relock.
module prbs_checker #(
    parameter int unsigned      WIDTH     = 3,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(3'b110),
    parameter int unsigned      LOCK_CNT  = 8,
    parameter int unsigned      WINDOW    = 64,
    parameter int unsigned      ERR_LIMIT = 4,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             data_valid_i,
    input  logic             data_in_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [CNT_W-1:0] error_count_o,
    output logic [CNT_W-1:0] bit_count_o,
    output logic [1:0]       state_out_o
);

    localparam int unsigned FillW  = $clog2(WIDTH + 1);
    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WinW   = $clog2(WINDOW + 1);
    localparam int unsigned ErrW   = $clog2(ERR_LIMIT + 1);

    localparam logic [FillW-1:0]  FillLast  = FillW'(WIDTH - 1);
    localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
    localparam logic [WinW-1:0]   WinLast   = WinW'(WINDOW - 1);
    localparam logic [ErrW-1:0]   ErrLast   = ErrW'(ERR_LIMIT - 1);

    typedef enum logic [1:0] {
        StAcq    = 2'b00,
        StVerify = 2'b01,
        StLocked = 2'b10,
        StLost   = 2'b11
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  s_q;
    logic [FillW-1:0]  fill_q;
    logic [MatchW-1:0] match_q;
    logic [WinW-1:0]   win_bits_q;
    logic [ErrW-1:0]   win_errs_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              locked_q;
    logic              err_pulse_q;

    logic             exp_bit;
    logic             bit_err;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_fly;

    assign exp_bit = ^(s_q & TAPS);
    assign bit_err = data_in_i ^ exp_bit;
    assign s_in    = {s_q[WIDTH-2:0], data_in_i};
    // Once locked the register free-runs on its own prediction so line errors never enter it.
    assign s_fly   = {s_q[WIDTH-2:0], exp_bit};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clock_in) begin
        if (!reset || clear_i) begin
            state_q     <= StAcq;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            unique case (state_q)
                StAcq: begin
                    if (data_valid_i) begin
                        s_q <= s_in;
                        if (fill_q == FillLast) begin
                            fill_q <= '0;
                            // An all-zero register would predict zeros forever; refill instead.
                            if (s_in != '0) begin
                                state_q <= StVerify;
                                match_q <= '0;
                            end
                        end else begin
                            fill_q <= fill_q + FillW'(1);
                        end
                    end
                end
                StVerify: begin
                    if (data_valid_i) begin
                        s_q <= s_in;
                        if (bit_err) begin
                            state_q <= StAcq;
                            fill_q  <= '0;
                        end else if (match_q == MatchLast) begin
                            state_q    <= StLocked;
                            locked_q   <= 1'b1;
                            win_bits_q <= '0;
                            win_errs_q <= '0;
                        end else begin
                            match_q <= match_q + MatchW'(1);
                        end
                    end
                end
                StLocked: begin
                    if (data_valid_i) begin
                        s_q         <= s_fly;
                        err_pulse_q <= bit_err;
                        bit_cnt_q   <= sat_inc(bit_cnt_q);
                        if (bit_err) begin
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end
                        if (bit_err && (win_errs_q == ErrLast)) begin
                            state_q    <= StLost;
                            locked_q   <= 1'b0;
                            win_bits_q <= '0;
                            win_errs_q <= '0;
                        end else if (win_bits_q == WinLast) begin
                            win_bits_q <= '0;
                            win_errs_q <= '0;
                        end else begin
                            win_bits_q <= win_bits_q + WinW'(1);
                            win_errs_q <= win_errs_q + ErrW'(bit_err);
                        end
                    end
                end
                StLost: begin
`ifdef PRBS_CHECKER_AUTORELOCK_EN
                    state_q <= StAcq;
                    fill_q  <= '0;
`else
                    state_q <= StLost;
`endif
                end
            endcase
        end
    end

    assign locked_o      = locked_q;
    assign err_pulse_o   = err_pulse_q;
    assign error_count_o = err_cnt_q;
    assign bit_count_o   = bit_cnt_q;
    assign state_out_o   = state_q;

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the on-board LFSR pattern generator.
- Samples a serial pseudo-random bit stream, self-synchronises a local LFSR to it, declares lock, then counts bit errors and detects loss of lock.
- Used for board loopback and link tests. Counters and state drive LEDs and the 7-seg debug display.

Parameters:
- WIDTH, 3: LFSR length in bits; legal range 3..16.
- TAPS, 3'b110: feedback mask over shift register s[WIDTH-1:0]; default gives b(n) = b(n-2) ^ b(n-3), period 7.
- LOCK_CNT, 8: consecutive matching bits required in VERIFY before lock.
- WINDOW, 64: bits per error-monitoring window in LOCKED.
- ERR_LIMIT, 4: errors within one window that declare loss of lock.
- CNT_W, 16: width of error_count and bit_count.

Ports:
- clock_in  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- clear  in  1  synchronous, active-high; zeroes counters and restarts acquisition.
- data_valid  in  1  qualifies data_in for one clock_in cycle (strobe from the divided-clock domain, already synchronised).
- data_in  in  1  PRBS bit under test.
- locked  out  1  high in LOCKED state.
- err_pulse  out  1  one-cycle pulse per mismatched bit in LOCKED.
- error_count  out  CNT_W  saturating count of errors since reset/clear.
- bit_count  out  CNT_W  saturating count of valid bits checked in LOCKED.
- state_out  out  2  00 ACQ, 01 VERIFY, 10 LOCKED, 11 LOST.

Behaviour:
- Reset (reset==0 at posedge):
  - state ACQ; s, fill counter, match counter, window counters = 0.
  - Outputs locked=0, err_pulse=0, error_count=0, bit_count=0, state_out=00.
- Cycles with data_valid=0: nothing advances. err_pulse=0.
- Shift rule: s <= {s[WIDTH-2:0], bit}. Expected bit e = ^(s & TAPS).
- ACQ:
  - Each valid bit shifts data_in into s.
  - After WIDTH valid bits, check s. If s==0 (lock-up pattern), restart the fill. Otherwise go to VERIFY with match counter = 0.
- VERIFY:
  - Each valid bit is compared with e, and data_in is shifted in.
  - Match: increment match counter. On reaching LOCK_CNT, go to LOCKED.
  - Mismatch: return to ACQ with fill counter = 0. Errors are not counted.
- LOCKED:
  - Each valid bit shifts in e (flywheel), not data_in, so single errors do not propagate.
  - On mismatch, err_pulse=1 for the next cycle and error_count increments.
  - Every valid bit increments bit_count and the window bit counter.
  - Window error counter reaches ERR_LIMIT (including the current bit): go to LOST that cycle; window counters cleared.
  - Window bit counter reaches WINDOW without hitting the limit: window counters cleared.
- LOST:
  - locked=0. Counters hold and s holds.
  - Exit behaviour is set by the optional feature.
- Latency: all outputs registered. Effects of a valid bit sampled at edge k are visible after edge k.
- Counters saturate at all-ones and never wrap. The window counters also run when the count outputs are saturated.
- Priority: reset > clear > data_valid processing.
  - clear coincident with a valid bit discards that bit.
  - clear in any state: ACQ, counters 0, s=0.
- Reset or clear mid-window or mid-VERIFY discards all partial state.

Optional Feature:
- Macro: PRBS_CHECKER_AUTORELOCK_EN
- Defined: LOST moves to ACQ on the next clock_in edge (fill counter 0). error_count and bit_count are retained across relock.
- Undefined: LOST is terminal until clear or reset, so the operator sees a latched loss on the LEDs.

Test Plan:
- Clean lock: reset low 2 cycles, then feed default period-7 stream 1,0,0,1,0,1,1 repeated, one valid per 2 clocks.
  - Required: state 00 to 01 after 3 valid bits, 10 after 11 valid bits, locked=1.
  - After 70 more bits: error_count=0, bit_count=70.
- Single error: once locked, invert one bit.
  - Required: exactly one err_pulse one cycle after that valid edge, error_count=1, locked stays 1.
  - Following bits produce no further errors.
- Loss of lock: once locked, invert 4 bits within 64.
  - Required: state_out=11 and locked=0 after the 4th.
  - With macro defined: state 00 next cycle. Without macro: state holds 11 for 200 cycles; clear returns to 00.
- All-zero seed: feed 0,0,0 then a valid stream.
  - Required: ACQ restarts and state stays 00 through the zero bits, then locks normally.
- VERIFY failure: corrupt bit 5 of VERIFY.
  - Required: state back to 00, error_count=0, then relock on a clean stream.
- Saturation and priority: with CNT_W=4, 20 errors paced so each window holds at most 3.
  - Required: error_count=15 (saturated).
  - clear asserted with data_valid=1: counters 0, state 00, bit discarded.
